risc_cu_param: RTL and testbench
================================

# risc_cu_param

Parametrised multi-cycle control unit for the 16-bit RISC processor. It sequences fetch, decode and execute and drives the execution unit and memory control word. Compared with the previous control unit it adds:
- parametrised register-address and instruction widths;
- a `mem_rdy` wait-state handshake;
- N-flag and not-carry branches;
- a single-level maskable interrupt with `EI`, `DI` and `RETI`;
- a `HALT` state that wakes on interrupt.

## Interface
- `RA_W`, default 3: register-address field width. Constraint: `IR_W-7 >= 3*RA_W`.
- `IR_W`, default 16: instruction width. The opcode is always `IR[IR_W-1:IR_W-7]`.
- `clk` input 1: clock, rising edge.
- `reset` input 1: reset, asynchronous, active-high.
- `IR` input `IR_W`: instruction register contents.
- `N`, `Z`, `C` input 1 each: live ALU status.
- `mem_rdy` input 1: memory completes the current access this cycle.
- `irq` input 1: level interrupt request.
- `W_Adr`, `R_Adr`, `S_Adr` output `RA_W` each: register-file addresses.
- `adr_sel`, `s_sel` output 1 each: memory-address mux and write-back mux selects.
- `pc_ld`, `pc_inc`, `ir_ld` output 1 each: PC load, PC increment, IR load.
- `pc_sel` output 2: PC source. 0 = PC+sign-extended `IR[7:0]`, 1 = `R[S]`, 2 = interrupt vector, 3 = EPC.
- `mw_en`, `mr_en`, `rw_en` output 1 each: memory write, memory read, register write.
- `epc_ld` output 1: EPC <- PC (EPC is a datapath register).
- `alu_op` output 4: ALU opcode.
- `irq_ack` output 1: interrupt accepted.
- `halted` output 1: state is `HALT` or `ILLEGAL`.
- `status` output 8: LED state display.

## Operation
Register-address fields:
- W = `IR[3*RA_W-1:2*RA_W]`
- R = `IR[2*RA_W-1:RA_W]`
- S = `IR[RA_W-1:0]`

Control-word defaults: every output is 0 unless listed for a state.

States and transitions:
- `RESET`
  - Flags and `ie` cleared; `status` = FF.
  - Next: `FETCH`.
- `FETCH`
  - If `irq & ie`: all outputs at default, next `INTR`. This takes priority over `mem_rdy`.
  - Otherwise `mr_en`=1 and `ir_ld`=`pc_inc`=`mem_rdy`; `status` = 80.
  - Next: `DECODE` when `mem_rdy`, else remain in `FETCH`.
- `DECODE`: `status` = C0; next state from the opcode.
  - 70 `ADD`, 71 `SUB`, 72 `CMP`, 73 `MOV`, 74 `SHL`, 75 `SHR`, 76 `INC`, 77 `DEC`
  - 78 `LD`, 79 `STO`, 7A `LDI`, 7B `HALT`
  - 7C `JE`, 7D `JNE`, 7E `JC`, 7F `JMP`
  - 6F `JN`, 6E `JNC`, 6D `EI`, 6C `DI`, 6B `RETI`
  - All other opcodes: `ILLEGAL`.
- ALU states: W/R/S addresses, `rw_en` and `alu_op` are as in the previous unit.
  - `ADD` 0100, `SUB` 0101, `CMP` 0101 (no write), `MOV` 0000, `SHL` 0111, `SHR` 0110, `INC` 0010, `DEC` 0011.
  - All except `MOV` latch {N,Z,C} at the end of the state.
- Memory states: each holds its control word until `mem_rdy`. `rw_en`, `mw_en` and `pc_inc` are gated by `mem_rdy`; `mr_en` is held for the whole wait.
  - `LD`: W=IR W field, R=IR S field, `adr_sel`=`s_sel`=1, `mr_en`=1, `rw_en`.
  - `STO`: R=IR W field, S=IR S field, `adr_sel`=1, `mw_en`.
  - `LDI`: W=IR W field, `s_sel`=1, `mr_en`=1, `rw_en`, `pc_inc`.
- Branches, all with `pc_sel`=0:
  - `JE`: `pc_ld`=`ps_Z`.
  - `JNE`: `pc_ld`=`!ps_Z`.
  - `JC`: `pc_ld`=`ps_C`.
  - `JNC`: `pc_ld`=`!ps_C`.
  - `JN`: `pc_ld`=`ps_N`.
- `JMP`: S=IR S field, `pc_ld`=1, `pc_sel`=1.
- `EI` / `DI`: `ie` <- 1 / 0 at the end of the state.
- `INTR`: `epc_ld`=1, `pc_ld`=1, `pc_sel`=2, `irq_ack`=1.
  - At the end of the state: saved flags <- {ps_N,ps_Z,ps_C} and `ie` <- 0.
- `RETI`: `pc_ld`=1, `pc_sel`=3.
  - At the end of the state: {ps_N,ps_Z,ps_C} <- saved flags and `ie` <- 1.
- `HALT`: flags are preserved.
  - Next: `INTR` if `irq & ie`, else remain in `HALT`.
- `ILLEGAL`: `status` = F0; remains there until `reset`.
- All execute states other than `HALT` and `ILLEGAL` go to `FETCH`.
- `status` in execute states is {ps_N,ps_Z,ps_C,code}:
  - codes 00000–01111 keep the previous assignment;
  - `JN` 10001, `JNC` 10010, `EI` 10011, `DI` 10100, `RETI` 10101, `INTR` 10110.

## Timing
- With `mem_rdy` tied to 1:
  - register, ALU and branch instructions take 3 cycles (FETCH, DECODE, execute);
  - an interrupt adds 1 cycle (`INTR`).
- Each `mem_rdy`=0 cycle in `FETCH`, `LD`, `STO` or `LDI` adds exactly one cycle. No strobe fires twice.
- Flags, `ie` and saved flags update only on the clock edge that leaves the state that writes them.
- Branches use registered flags, so `CMP` followed by `JE` sees the `CMP` result.
- `irq` is sampled only in `FETCH` and `HALT`. An `EI` takes effect at the next `FETCH`.
- Reset values: state `RESET`, flags 0, `ie` 0, saved flags 0, all control outputs 0, `status` FF, `halted` 0.
- A `reset` during a wait state aborts the access immediately.

## Structure
- Package `risc_cu_pkg`:
  - state enum (5 bits);
  - opcode constants;
  - `alu_op` constants;
  - `pc_sel` encodings;
  - status codes.
- Sub-module `risc_cu_flags`: holds the ps flag register, saved-flag register and `ie` bit, with load, save, restore and set/clear controls.
- The sequencer and control-word decode stay in `risc_cu_param`.

## Test plan
- Reset, then `ADD` (IR=E0D1) with `mem_rdy`=1 → states 1,2,3,1; W=3, R=2, S=1, `rw_en`=1, `alu_op`=0100 in cycle 3.
- `mem_rdy` low for 2 cycles during `FETCH` → `mr_en` high for 3 cycles; `ir_ld` and `pc_inc` each pulse exactly once.
- `CMP` producing Z=1, then `JE` → `pc_ld`=1, `pc_sel`=0; `JNE` in the same situation → `pc_ld`=0.
- `EI` then `irq`=1 → next FETCH goes to `INTR`: `epc_ld`, `pc_sel`=2, `irq_ack`; a following `RETI` restores N,Z,C=1,0,1 and `ie`=1.
- `HALT` with `ie`=0 and `irq`=1 → stays halted; with `ie`=1 → `INTR` on the next cycle.
- Opcode 00 → `ILLEGAL` with `status`=F0; asserting `reset` mid-`LD` wait → outputs 0 and `status`=FF immediately.

Source files
------------

// File: rtl/risc_cu_pkg.sv
// Shared encodings for the parametrised RISC control unit: states, opcodes,
// ALU operations, PC source selects and status display codes.
package risc_cu_pkg;

    typedef enum logic [4:0] {
        S_RESET   = 5'd0,
        S_FETCH   = 5'd1,
        S_DECODE  = 5'd2,
        S_ADD     = 5'd3,
        S_SUB     = 5'd4,
        S_CMP     = 5'd5,
        S_MOV     = 5'd6,
        S_SHL     = 5'd7,
        S_SHR     = 5'd8,
        S_INC     = 5'd9,
        S_DEC     = 5'd10,
        S_LD      = 5'd11,
        S_STO     = 5'd12,
        S_LDI     = 5'd13,
        S_HALT    = 5'd14,
        S_JE      = 5'd15,
        S_JNE     = 5'd16,
        S_JC      = 5'd17,
        S_JMP     = 5'd18,
        S_JN      = 5'd19,
        S_JNC     = 5'd20,
        S_EI      = 5'd21,
        S_DI      = 5'd22,
        S_RETI    = 5'd23,
        S_INTR    = 5'd24,
        S_ILLEGAL = 5'd25
    } state_t;

    localparam logic [6:0] OP_ADD  = 7'h70;
    localparam logic [6:0] OP_SUB  = 7'h71;
    localparam logic [6:0] OP_CMP  = 7'h72;
    localparam logic [6:0] OP_MOV  = 7'h73;
    localparam logic [6:0] OP_SHL  = 7'h74;
    localparam logic [6:0] OP_SHR  = 7'h75;
    localparam logic [6:0] OP_INC  = 7'h76;
    localparam logic [6:0] OP_DEC  = 7'h77;
    localparam logic [6:0] OP_LD   = 7'h78;
    localparam logic [6:0] OP_STO  = 7'h79;
    localparam logic [6:0] OP_LDI  = 7'h7A;
    localparam logic [6:0] OP_HALT = 7'h7B;
    localparam logic [6:0] OP_JE   = 7'h7C;
    localparam logic [6:0] OP_JNE  = 7'h7D;
    localparam logic [6:0] OP_JC   = 7'h7E;
    localparam logic [6:0] OP_JMP  = 7'h7F;
    localparam logic [6:0] OP_JN   = 7'h6F;
    localparam logic [6:0] OP_JNC  = 7'h6E;
    localparam logic [6:0] OP_EI   = 7'h6D;
    localparam logic [6:0] OP_DI   = 7'h6C;
    localparam logic [6:0] OP_RETI = 7'h6B;

    localparam logic [3:0] ALU_MOV = 4'b0000;
    localparam logic [3:0] ALU_INC = 4'b0010;
    localparam logic [3:0] ALU_DEC = 4'b0011;
    localparam logic [3:0] ALU_ADD = 4'b0100;
    localparam logic [3:0] ALU_SUB = 4'b0101;
    localparam logic [3:0] ALU_SHR = 4'b0110;
    localparam logic [3:0] ALU_SHL = 4'b0111;

    localparam logic [1:0] PC_REL = 2'd0;
    localparam logic [1:0] PC_REG = 2'd1;
    localparam logic [1:0] PC_VEC = 2'd2;
    localparam logic [1:0] PC_EPC = 2'd3;

    localparam logic [7:0] STAT_RESET   = 8'hFF;
    localparam logic [7:0] STAT_FETCH   = 8'h80;
    localparam logic [7:0] STAT_DECODE  = 8'hC0;
    localparam logic [7:0] STAT_ILLEGAL = 8'hF0;

    // Execute-state codes 00..0F follow opcode order 70..7F of the older unit.
    localparam logic [4:0] SC_ADD  = 5'h00;
    localparam logic [4:0] SC_SUB  = 5'h01;
    localparam logic [4:0] SC_CMP  = 5'h02;
    localparam logic [4:0] SC_MOV  = 5'h03;
    localparam logic [4:0] SC_SHL  = 5'h04;
    localparam logic [4:0] SC_SHR  = 5'h05;
    localparam logic [4:0] SC_INC  = 5'h06;
    localparam logic [4:0] SC_DEC  = 5'h07;
    localparam logic [4:0] SC_LD   = 5'h08;
    localparam logic [4:0] SC_STO  = 5'h09;
    localparam logic [4:0] SC_LDI  = 5'h0A;
    localparam logic [4:0] SC_HALT = 5'h0B;
    localparam logic [4:0] SC_JE   = 5'h0C;
    localparam logic [4:0] SC_JNE  = 5'h0D;
    localparam logic [4:0] SC_JC   = 5'h0E;
    localparam logic [4:0] SC_JMP  = 5'h0F;
    localparam logic [4:0] SC_JN   = 5'h11;
    localparam logic [4:0] SC_JNC  = 5'h12;
    localparam logic [4:0] SC_EI   = 5'h13;
    localparam logic [4:0] SC_DI   = 5'h14;
    localparam logic [4:0] SC_RETI = 5'h15;
    localparam logic [4:0] SC_INTR = 5'h16;

    function automatic state_t decode_op(input logic [6:0] op);
        case (op)
            OP_ADD:  return S_ADD;
            OP_SUB:  return S_SUB;
            OP_CMP:  return S_CMP;
            OP_MOV:  return S_MOV;
            OP_SHL:  return S_SHL;
            OP_SHR:  return S_SHR;
            OP_INC:  return S_INC;
            OP_DEC:  return S_DEC;
            OP_LD:   return S_LD;
            OP_STO:  return S_STO;
            OP_LDI:  return S_LDI;
            OP_HALT: return S_HALT;
            OP_JE:   return S_JE;
            OP_JNE:  return S_JNE;
            OP_JC:   return S_JC;
            OP_JMP:  return S_JMP;
            OP_JN:   return S_JN;
            OP_JNC:  return S_JNC;
            OP_EI:   return S_EI;
            OP_DI:   return S_DI;
            OP_RETI: return S_RETI;
            default: return S_ILLEGAL;
        endcase
    endfunction

    function automatic logic [3:0] alu_op_of(input state_t s);
        case (s)
            S_ADD:        return ALU_ADD;
            S_SUB, S_CMP: return ALU_SUB;
            S_SHL:        return ALU_SHL;
            S_SHR:        return ALU_SHR;
            S_INC:        return ALU_INC;
            S_DEC:        return ALU_DEC;
            default:      return ALU_MOV;
        endcase
    endfunction

    function automatic logic [4:0] exec_code(input state_t s);
        case (s)
            S_ADD:   return SC_ADD;
            S_SUB:   return SC_SUB;
            S_CMP:   return SC_CMP;
            S_MOV:   return SC_MOV;
            S_SHL:   return SC_SHL;
            S_SHR:   return SC_SHR;
            S_INC:   return SC_INC;
            S_DEC:   return SC_DEC;
            S_LD:    return SC_LD;
            S_STO:   return SC_STO;
            S_LDI:   return SC_LDI;
            S_HALT:  return SC_HALT;
            S_JE:    return SC_JE;
            S_JNE:   return SC_JNE;
            S_JC:    return SC_JC;
            S_JMP:   return SC_JMP;
            S_JN:    return SC_JN;
            S_JNC:   return SC_JNC;
            S_EI:    return SC_EI;
            S_DI:    return SC_DI;
            S_RETI:  return SC_RETI;
            S_INTR:  return SC_INTR;
            default: return 5'h00;
        endcase
    endfunction

endpackage

// File: rtl/risc_cu_if.sv
// Control-unit to datapath bundle: instruction/status inputs and the control word.
interface risc_cu_if #(
    parameter int RA_W = 3,
    parameter int IR_W = 16
);
    logic [IR_W-1:0] IR;
    logic            N;
    logic            Z;
    logic            C;
    logic            mem_rdy;
    logic            irq;
    logic [RA_W-1:0] W_Adr;
    logic [RA_W-1:0] R_Adr;
    logic [RA_W-1:0] S_Adr;
    logic            adr_sel;
    logic            s_sel;
    logic            pc_ld;
    logic            pc_inc;
    logic            ir_ld;
    logic [1:0]      pc_sel;
    logic            mw_en;
    logic            mr_en;
    logic            rw_en;
    logic            epc_ld;
    logic [3:0]      alu_op;
    logic            irq_ack;
    logic            halted;
    logic [7:0]      status;

    modport master (
        input  IR, N, Z, C, mem_rdy, irq,
        output W_Adr, R_Adr, S_Adr, adr_sel, s_sel, pc_ld, pc_inc, ir_ld,
               pc_sel, mw_en, mr_en, rw_en, epc_ld, alu_op, irq_ack, halted, status
    );

    modport slave (
        output IR, N, Z, C, mem_rdy, irq,
        input  W_Adr, R_Adr, S_Adr, adr_sel, s_sel, pc_ld, pc_inc, ir_ld,
               pc_sel, mw_en, mr_en, rw_en, epc_ld, alu_op, irq_ack, halted, status
    );
endinterface

// File: rtl/risc_cu_flags.sv
// Processor status flags {N,Z,C}, interrupt-saved copy and interrupt-enable bit.
module risc_cu_flags (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic [2:0] nzc,
    input  logic       ps_ld,
    input  logic       save,
    input  logic       restore,
    input  logic       ie_set,
    input  logic       ie_clr,
    output logic [2:0] ps,
    output logic       ie
);
    logic [2:0] saved;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ps    <= '0;
            saved <= '0;
            ie    <= 1'b0;
        end else if (clr) begin
            ps    <= '0;
            saved <= '0;
            ie    <= 1'b0;
        end else begin
            if (ps_ld)
                ps <= nzc;
            else if (restore)
                ps <= saved;
            if (save)
                saved <= ps;
            if (ie_set)
                ie <= 1'b1;
            else if (ie_clr)
                ie <= 1'b0;
        end
    end
endmodule

// File: rtl/risc_cu_param.sv
// Multi-cycle fetch/decode/execute sequencer for the 16-bit RISC, with memory
// wait states and a single-level maskable interrupt.
module risc_cu_param #(
    parameter int RA_W = 3,
    parameter int IR_W = 16
) (
    input logic       clk,
    input logic       reset,
    risc_cu_if.master cu
);
    import risc_cu_pkg::*;

    state_t          state;
    state_t          next_state;
    logic [6:0]      opcode;
    logic [RA_W-1:0] f_w;
    logic [RA_W-1:0] f_r;
    logic [RA_W-1:0] f_s;
    logic [2:0]      ps;
    logic            ie;
    logic            flags_clr;
    logic            ps_ld;
    logic            flags_save;
    logic            flags_restore;
    logic            ie_set;
    logic            ie_clr;

    assign opcode = cu.IR[IR_W-1 -: 7];
    assign f_w    = cu.IR[3*RA_W-1 -: RA_W];
    assign f_r    = cu.IR[2*RA_W-1 -: RA_W];
    assign f_s    = cu.IR[RA_W-1:0];

    risc_cu_flags u_flags (
        .clk     (clk),
        .reset   (reset),
        .clr     (flags_clr),
        .nzc     ({cu.N, cu.Z, cu.C}),
        .ps_ld   (ps_ld),
        .save    (flags_save),
        .restore (flags_restore),
        .ie_set  (ie_set),
        .ie_clr  (ie_clr),
        .ps      (ps),
        .ie      (ie)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= S_RESET;
        else
            state <= next_state;
    end

    always_comb begin
        next_state    = state;
        cu.W_Adr      = '0;
        cu.R_Adr      = '0;
        cu.S_Adr      = '0;
        cu.adr_sel    = 1'b0;
        cu.s_sel      = 1'b0;
        cu.pc_ld      = 1'b0;
        cu.pc_inc     = 1'b0;
        cu.ir_ld      = 1'b0;
        cu.pc_sel     = PC_REL;
        cu.mw_en      = 1'b0;
        cu.mr_en      = 1'b0;
        cu.rw_en      = 1'b0;
        cu.epc_ld     = 1'b0;
        cu.alu_op     = ALU_MOV;
        cu.irq_ack    = 1'b0;
        cu.halted     = 1'b0;
        cu.status     = {ps, exec_code(state)};
        flags_clr     = 1'b0;
        ps_ld         = 1'b0;
        flags_save    = 1'b0;
        flags_restore = 1'b0;
        ie_set        = 1'b0;
        ie_clr        = 1'b0;

        case (state)
            S_RESET: begin
                cu.status  = STAT_RESET;
                flags_clr  = 1'b1;
                next_state = S_FETCH;
            end
            S_FETCH: begin
                // A pending enabled interrupt pre-empts the fetch entirely.
                if (cu.irq && ie) begin
                    cu.status  = '0;
                    next_state = S_INTR;
                end else begin
                    cu.status = STAT_FETCH;
                    cu.mr_en  = 1'b1;
                    cu.ir_ld  = cu.mem_rdy;
                    cu.pc_inc = cu.mem_rdy;
                    if (cu.mem_rdy)
                        next_state = S_DECODE;
                end
            end
            S_DECODE: begin
                cu.status  = STAT_DECODE;
                next_state = decode_op(opcode);
            end
            S_ADD, S_SUB, S_CMP, S_MOV, S_SHL, S_SHR, S_INC, S_DEC: begin
                cu.W_Adr   = f_w;
                cu.R_Adr   = f_r;
                cu.S_Adr   = f_s;
                cu.rw_en   = (state != S_CMP);
                cu.alu_op  = alu_op_of(state);
                ps_ld      = (state != S_MOV);
                next_state = S_FETCH;
            end
            S_LD: begin
                cu.W_Adr   = f_w;
                cu.R_Adr   = f_s;
                cu.adr_sel = 1'b1;
                cu.s_sel   = 1'b1;
                cu.mr_en   = 1'b1;
                cu.rw_en   = cu.mem_rdy;
                if (cu.mem_rdy)
                    next_state = S_FETCH;
            end
            S_STO: begin
                cu.R_Adr   = f_w;
                cu.S_Adr   = f_s;
                cu.adr_sel = 1'b1;
                cu.mw_en   = cu.mem_rdy;
                if (cu.mem_rdy)
                    next_state = S_FETCH;
            end
            S_LDI: begin
                cu.W_Adr   = f_w;
                cu.s_sel   = 1'b1;
                cu.mr_en   = 1'b1;
                cu.rw_en   = cu.mem_rdy;
                cu.pc_inc  = cu.mem_rdy;
                if (cu.mem_rdy)
                    next_state = S_FETCH;
            end
            S_HALT: begin
                cu.halted = 1'b1;
                if (cu.irq && ie)
                    next_state = S_INTR;
            end
            // Conditional branches test the registered flags, not the live ALU status.
            S_JE: begin
                cu.pc_ld   = ps[1];
                next_state = S_FETCH;
            end
            S_JNE: begin
                cu.pc_ld   = !ps[1];
                next_state = S_FETCH;
            end
            S_JC: begin
                cu.pc_ld   = ps[0];
                next_state = S_FETCH;
            end
            S_JNC: begin
                cu.pc_ld   = !ps[0];
                next_state = S_FETCH;
            end
            S_JN: begin
                cu.pc_ld   = ps[2];
                next_state = S_FETCH;
            end
            S_JMP: begin
                cu.S_Adr   = f_s;
                cu.pc_ld   = 1'b1;
                cu.pc_sel  = PC_REG;
                next_state = S_FETCH;
            end
            S_EI: begin
                ie_set     = 1'b1;
                next_state = S_FETCH;
            end
            S_DI: begin
                ie_clr     = 1'b1;
                next_state = S_FETCH;
            end
            S_INTR: begin
                cu.epc_ld  = 1'b1;
                cu.pc_ld   = 1'b1;
                cu.pc_sel  = PC_VEC;
                cu.irq_ack = 1'b1;
                flags_save = 1'b1;
                ie_clr     = 1'b1;
                next_state = S_FETCH;
            end
            S_RETI: begin
                cu.pc_ld      = 1'b1;
                cu.pc_sel     = PC_EPC;
                flags_restore = 1'b1;
                ie_set        = 1'b1;
                next_state    = S_FETCH;
            end
            S_ILLEGAL: begin
                cu.status = STAT_ILLEGAL;
                cu.halted = 1'b1;
            end
            default: next_state = S_ILLEGAL;
        endcase
    end
endmodule

// File: tb/tb_risc_cu_param.sv
// Directed bench for risc_cu_param: instruction sequences with hand-computed control words.
module tb_risc_cu_param;
    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   mr_cnt = 0;
    int   ir_cnt = 0;
    int   inc_cnt = 0;

    risc_cu_if #(.RA_W(3), .IR_W(16)) cu ();

    risc_cu_param #(.RA_W(3), .IR_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .cu    (cu)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset      = 1'b1;
        cu.IR      = 16'h0000;
        cu.N       = 1'b0;
        cu.Z       = 1'b0;
        cu.C       = 1'b0;
        cu.mem_rdy = 1'b1;
        cu.irq     = 1'b0;
        #1;
        chk("rst_state",  dut.state, 0);
        chk("rst_status", cu.status, 8'hFF);
        chk("rst_halted", cu.halted, 0);
        chk("rst_mr_en",  cu.mr_en, 0);
        tick(); tick();
        reset = 1'b0;

        // ADD R3 <- R2 + R1
        cu.IR = 16'hE0D1;
        tick();
        chk("add_fetch_state", dut.state, 1);
        chk("fetch_mr_en", cu.mr_en, 1);
        chk("fetch_ir_ld", cu.ir_ld, 1);
        chk("fetch_pc_inc", cu.pc_inc, 1);
        chk("fetch_status", cu.status, 8'h80);
        tick();
        chk("add_decode_state", dut.state, 2);
        chk("decode_status", cu.status, 8'hC0);
        tick();
        chk("add_exec_state", dut.state, 3);
        chk("add_w", cu.W_Adr, 3);
        chk("add_r", cu.R_Adr, 2);
        chk("add_s", cu.S_Adr, 1);
        chk("add_rw_en", cu.rw_en, 1);
        chk("add_alu_op", cu.alu_op, 4'b0100);
        tick();
        chk("add_back_fetch", dut.state, 1);

        // Two wait states in FETCH
        cu.IR = 16'hE400;
        for (int i = 0; i < 3; i++) begin
            cu.mem_rdy = (i == 2);
            #1;
            mr_cnt  += int'(cu.mr_en);
            ir_cnt  += int'(cu.ir_ld);
            inc_cnt += int'(cu.pc_inc);
            tick();
        end
        chk("wait_mr_en_cycles", mr_cnt, 3);
        chk("wait_ir_ld_pulses", ir_cnt, 1);
        chk("wait_pc_inc_pulses", inc_cnt, 1);
        chk("wait_decode_state", dut.state, 2);

        // CMP giving Z=1, then JE and JNE with live Z back at 0
        tick();
        cu.Z = 1'b1;
        #1;
        chk("cmp_state", dut.state, 5);
        chk("cmp_rw_en", cu.rw_en, 0);
        chk("cmp_alu_op", cu.alu_op, 4'b0101);
        tick();
        cu.Z  = 1'b0;
        cu.IR = 16'hF800;
        tick(); tick();
        chk("je_pc_ld", cu.pc_ld, 1);
        chk("je_pc_sel", cu.pc_sel, 0);
        chk("je_status", cu.status, 8'h4C);
        tick();
        cu.IR = 16'hFA00;
        tick(); tick();
        chk("jne_pc_ld", cu.pc_ld, 0);
        chk("jne_status", cu.status, 8'h4D);
        tick();

        // ADD leaving N,Z,C = 1,0,1, then EI and an interrupt
        cu.IR = 16'hE0D1;
        tick(); tick();
        cu.N = 1'b1; cu.Z = 1'b0; cu.C = 1'b1;
        tick();
        cu.N = 1'b0; cu.C = 1'b0;
        cu.IR = 16'hDA00;
        tick(); tick();
        chk("ei_status", cu.status, 8'hB3);
        cu.irq = 1'b1;
        tick();
        chk("irq_fetch_mr_en", cu.mr_en, 0);
        chk("irq_fetch_ir_ld", cu.ir_ld, 0);
        tick();
        chk("intr_epc_ld", cu.epc_ld, 1);
        chk("intr_pc_ld", cu.pc_ld, 1);
        chk("intr_pc_sel", cu.pc_sel, 2);
        chk("intr_irq_ack", cu.irq_ack, 1);
        chk("intr_status", cu.status, 8'hB6);
        tick();
        chk("intr_ie_cleared", cu.mr_en, 1);
        cu.irq = 1'b0;
        // CMP overwrites flags with 0,1,0 before RETI
        cu.IR = 16'hE400;
        tick(); tick();
        cu.Z = 1'b1;
        tick();
        cu.Z  = 1'b0;
        cu.IR = 16'hD600;
        tick(); tick();
        chk("reti_pc_ld", cu.pc_ld, 1);
        chk("reti_pc_sel", cu.pc_sel, 3);
        chk("reti_status", cu.status, 8'h55);
        cu.irq = 1'b1;
        tick();
        chk("reti_ie_set", cu.mr_en, 0);
        tick();
        chk("reti_flags_restored", cu.status, 8'hB6);
        cu.irq = 1'b0;
        tick();

        // HALT with ie=0 ignores irq
        cu.IR = 16'hF600;
        tick(); tick();
        chk("halt_halted", cu.halted, 1);
        chk("halt_status", cu.status, 8'hAB);
        cu.irq = 1'b1;
        tick();
        chk("halt_ie0_stays", cu.halted, 1);
        chk("halt_ie0_no_ack", cu.irq_ack, 0);
        reset = 1'b1;
        #1;
        chk("halt_reset_status", cu.status, 8'hFF);
        chk("halt_reset_halted", cu.halted, 0);
        tick();
        reset  = 1'b0;
        cu.irq = 1'b0;
        tick();

        // EI, then HALT woken by irq
        cu.IR = 16'hDA00;
        tick(); tick(); tick();
        cu.IR = 16'hF600;
        tick(); tick();
        chk("halt2_status", cu.status, 8'h0B);
        cu.irq = 1'b1;
        #1;
        chk("halt2_halted", cu.halted, 1);
        tick();
        chk("halt_wake_irq_ack", cu.irq_ack, 1);
        chk("halt_wake_halted", cu.halted, 0);
        cu.irq = 1'b0;
        tick();

        // Opcode 00 is illegal and sticks
        cu.IR = 16'h0000;
        tick(); tick();
        chk("illegal_status", cu.status, 8'hF0);
        chk("illegal_halted", cu.halted, 1);
        tick();
        chk("illegal_sticks", cu.status, 8'hF0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();

        // STO with one wait state
        cu.IR = 16'hF284;
        tick();
        cu.mem_rdy = 1'b0;
        tick();
        chk("sto_r", cu.R_Adr, 2);
        chk("sto_s", cu.S_Adr, 4);
        chk("sto_adr_sel", cu.adr_sel, 1);
        chk("sto_wait_mw_en", cu.mw_en, 0);
        tick();
        cu.mem_rdy = 1'b1;
        #1;
        chk("sto_rdy_mw_en", cu.mw_en, 1);
        tick();

        // LD waiting, aborted by reset
        cu.IR = 16'hF146;
        tick();
        cu.mem_rdy = 1'b0;
        tick();
        chk("ld_mr_en", cu.mr_en, 1);
        chk("ld_wait_rw_en", cu.rw_en, 0);
        chk("ld_w", cu.W_Adr, 5);
        chk("ld_r", cu.R_Adr, 6);
        chk("ld_s_sel", cu.s_sel, 1);
        tick();
        chk("ld_still_waiting", dut.state, 11);
        reset = 1'b1;
        #1;
        chk("ld_abort_mr_en", cu.mr_en, 0);
        chk("ld_abort_adr_sel", cu.adr_sel, 0);
        chk("ld_abort_status", cu.status, 8'hFF);
        chk("ld_abort_state", dut.state, 0);
        reset      = 1'b0;
        cu.mem_rdy = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
